pixel_reorder_stream: RTL and testbench
=======================================

PIXEL_REORDER_STREAM -- requirements
Module: pixel_reorder_stream

Interface
REQ-001 Parameters SHALL be: NUM_ENGINES, default 8, number of engine result channels; PIXEL_W, default 10, coordinate width; ITER_W, default 6, iteration-count width (1..8); SLOT_DEPTH, default 4, per-channel FIFO depth (power of 2, >=2); H_RES, default 640, pixels per line; V_RES, default 480, lines per frame.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 iterations_max  in  ITER_W  escape limit; iter == iterations_max means in-set.
REQ-005 colour_mode  in  1  0 = greyscale, 1 = two-tone.
REQ-006 eng_valid  in  NUM_ENGINES  per-channel result valid.
REQ-007 eng_ready  out  NUM_ENGINES  per-channel accept; high when that channel's FIFO is not full.
REQ-008 eng_x, eng_y  in  NUM_ENGINES*PIXEL_W each  packed result coordinates; channel k at bits [k*PIXEL_W +: PIXEL_W].
REQ-009 eng_iter  in  NUM_ENGINES*ITER_W  packed result iteration counts.
REQ-010 ready  in  1  downstream accept.
REQ-011 r, g, b  out  8 each  output pixel colour.
REQ-012 valid, first, last_x, last_y  out  1 each  stream qualifiers.
REQ-013 frame_done  out  1  one-cycle pulse on final-pixel handshake.
REQ-014 order_err  out  1  sticky deadlock flag.

Function
REQ-015 Each channel SHALL own a SLOT_DEPTH FIFO of {x,y,iter}; push on eng_valid[k] & eng_ready[k]; full FIFO SHALL deassert eng_ready[k] the same cycle; push and pop in the same cycle on a full FIFO SHALL NOT be accepted.
REQ-016 An expected-coordinate counter (exp_x, exp_y) SHALL start at (0,0), advance exp_x on each pop, wrap exp_x at H_RES-1 to 0 and increment exp_y, and wrap (H_RES-1, V_RES-1) to (0,0).
REQ-017 Each cycle, non-empty FIFO heads SHALL be compared to (exp_x, exp_y); if several match, lowest channel index wins.
REQ-018 Pop SHALL occur when a match exists and the output register is empty or (valid & ready) this cycle.
REQ-019 Popped pixel SHALL appear on outputs the next cycle with valid=1 (latency 1 from pop); outputs SHALL hold stable while valid & !ready.
REQ-020 first=1 iff output pixel is (0,0); last_x=1 iff x == H_RES-1; last_y=1 iff x == H_RES-1 and y == V_RES-1.
REQ-021 Colour: iter == iterations_max SHALL give r=g=b=0; otherwise let s = iter left-shifted by 8-ITER_W into 8 bits; mode 0: r=g=b=s; mode 1: r=s, g=~s, b=8'h80.
REQ-022 iterations_max and colour_mode SHALL be sampled into shadow registers only on a pop of pixel (0,0) and used for the whole frame.
REQ-023 frame_done SHALL pulse one cycle on the handshake (valid & ready) of the last_y pixel.
REQ-024 order_err SHALL set when all FIFOs are full and no head matches for 2 consecutive cycles; cleared only by reset; blocks nothing.
REQ-025 A head whose coordinate is out of range (x >= H_RES or y >= V_RES) SHALL be dropped without output and SHALL set order_err.
REQ-026 Simultaneous push to and pop from the same non-full FIFO SHALL both take effect.

Reset
REQ-027 On reset: all FIFOs empty, exp = (0,0), valid=first=last_x=last_y=frame_done=order_err=0, r=g=b=0, shadow iterations_max=all ones, shadow colour_mode=0, eng_ready all 1 in the cycle after reset deasserts.
REQ-028 Reset asserted mid-frame SHALL discard all buffered and in-flight pixels; next frame restarts at (0,0).

Verification
REQ-029 H_RES=4,V_RES=2, channel 1 pushes (1,0), channel 0 pushes (0,0) a cycle later, ready=1 -> output (0,0) with first=1, then (1,0).
REQ-030 Fill channel 0 with 4 entries, ready=0 -> eng_ready[0]=0 after 4th push, output holds first pixel stable; ready=1 drains in order.
REQ-031 iterations_max=63, iter=63 -> rgb=000000; iter=1, mode 1 -> r=04, g=FB, b=80.
REQ-032 Stream full 4x2 frame -> last_x on x=3 pixels, last_y and frame_done only on (3,1); next pixel (0,0) has first=1.
REQ-033 All FIFOs full with coordinates not matching (0,0) -> order_err=1 after 2 cycles, stays 1 until reset.
REQ-034 Reset asserted with 3 pixels buffered -> next cycle valid=0, eng_ready all 1, exp=(0,0).

Source files
------------

// File: rtl/pixel_reorder_stream.sv
// Reorders out-of-order engine results into raster order and colours each pixel.
// One small FIFO per engine channel feeds a head comparator against the expected coordinate.
module pixel_reorder_stream #(
  parameter int NUM_ENGINES = 8,
  parameter int PIXEL_W     = 10,
  parameter int ITER_W      = 6,
  parameter int SLOT_DEPTH  = 4,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ITER_W-1:0]              iterations_max,
  input  logic                           colour_mode,
  input  logic [NUM_ENGINES-1:0]         eng_valid,
  output logic [NUM_ENGINES-1:0]         eng_ready,
  input  logic [NUM_ENGINES*PIXEL_W-1:0] eng_x,
  input  logic [NUM_ENGINES*PIXEL_W-1:0] eng_y,
  input  logic [NUM_ENGINES*ITER_W-1:0]  eng_iter,
  input  logic                           ready,
  output logic [7:0]                     r,
  output logic [7:0]                     g,
  output logic [7:0]                     b,
  output logic                           valid,
  output logic                           first,
  output logic                           last_x,
  output logic                           last_y,
  output logic                           frame_done,
  output logic                           order_err
);
  localparam int PTR_W = $clog2(SLOT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PIXEL_W-1:0] mem_x [NUM_ENGINES][SLOT_DEPTH];
  logic [PIXEL_W-1:0] mem_y [NUM_ENGINES][SLOT_DEPTH];
  logic [ITER_W-1:0]  mem_i [NUM_ENGINES][SLOT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr [NUM_ENGINES];
  logic [PTR_W-1:0]   rd_ptr [NUM_ENGINES];
  logic [CNT_W-1:0]   cnt    [NUM_ENGINES];

  logic [PIXEL_W-1:0] head_x [NUM_ENGINES];
  logic [PIXEL_W-1:0] head_y [NUM_ENGINES];
  logic [NUM_ENGINES-1:0] full, push, pop, drop, match, grant;
  logic [ITER_W-1:0]  sel_iter;
  logic               found, pop_en, at_origin, deadlock;

  logic [PIXEL_W-1:0] exp_x, exp_y;
  logic [ITER_W-1:0]  imax_sh;
  logic               mode_sh, stall_p1;
  logic               vld_p1, first_p1, last_x_p1, last_y_p1;
  logic [7:0]         r_p1, g_p1, b_p1;
  logic [23:0]        rgb_p0;

  function automatic logic [23:0] colour_fn(input logic [ITER_W-1:0] it,
                                            input logic [ITER_W-1:0] imax,
                                            input logic mode);
    logic [7:0] s;
    s = 8'(it) << (8 - ITER_W);
    if (it == imax)  return 24'h000000;
    else if (!mode)  return {s, s, s};
    else             return {s, ~s, 8'h80};
  endfunction

  assign eng_ready = ~full;
  assign push      = eng_valid & ~full;
  assign at_origin = (exp_x == '0) && (exp_y == '0);

  // Stage p0: head compare, out-of-range drop and lowest-index arbitration
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    sel_iter = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      full[k]   = (cnt[k] == CNT_W'(SLOT_DEPTH));
      head_x[k] = mem_x[k][rd_ptr[k]];
      head_y[k] = mem_y[k][rd_ptr[k]];
      drop[k]   = (cnt[k] != '0) &&
                  ((32'(head_x[k]) >= 32'(H_RES)) || (32'(head_y[k]) >= 32'(V_RES)));
      match[k]  = (cnt[k] != '0) && !drop[k] &&
                  (head_x[k] == exp_x) && (head_y[k] == exp_y);
      if (match[k] && !found) begin
        grant[k] = 1'b1;
        found    = 1'b1;
        sel_iter = mem_i[k][rd_ptr[k]];
      end
    end
    pop_en   = found && (!vld_p1 || ready);
    pop      = drop | (grant & {NUM_ENGINES{pop_en}});
    deadlock = (&full) && !(|match);
    rgb_p0   = at_origin ? colour_fn(sel_iter, iterations_max, colour_mode)
                         : colour_fn(sel_iter, imax_sh, mode_sh);
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (push[k]) begin
        mem_x[k][wr_ptr[k]] <= eng_x[k*PIXEL_W +: PIXEL_W];
        mem_y[k][wr_ptr[k]] <= eng_y[k*PIXEL_W +: PIXEL_W];
        mem_i[k][wr_ptr[k]] <= eng_iter[k*ITER_W +: ITER_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_ENGINES; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_ENGINES; k++) begin
        if (push[k]) wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop[k])  rd_ptr[k] <= rd_ptr[k] + 1'b1;
        cnt[k] <= cnt[k] + CNT_W'(push[k]) - CNT_W'(pop[k]);
      end
    end
  end

  // Stage p1: output register, raster counter, frame shadows and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_x     <= '0;
      exp_y     <= '0;
      imax_sh   <= '1;
      mode_sh   <= 1'b0;
      stall_p1  <= 1'b0;
      order_err <= 1'b0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_x_p1 <= 1'b0;
      last_y_p1 <= 1'b0;
      r_p1      <= '0;
      g_p1      <= '0;
      b_p1      <= '0;
    end else begin
      stall_p1 <= deadlock;
      if ((deadlock && stall_p1) || (|drop)) order_err <= 1'b1;
      if (pop_en) begin
        vld_p1    <= 1'b1;
        first_p1  <= at_origin;
        last_x_p1 <= (exp_x == PIXEL_W'(H_RES - 1));
        last_y_p1 <= (exp_x == PIXEL_W'(H_RES - 1)) && (exp_y == PIXEL_W'(V_RES - 1));
        {r_p1, g_p1, b_p1} <= rgb_p0;
        if (at_origin) begin
          imax_sh <= iterations_max;
          mode_sh <= colour_mode;
        end
        if (exp_x == PIXEL_W'(H_RES - 1)) begin
          exp_x <= '0;
          exp_y <= (exp_y == PIXEL_W'(V_RES - 1)) ? '0 : exp_y + 1'b1;
        end else begin
          exp_x <= exp_x + 1'b1;
        end
      end else if (ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign valid      = vld_p1;
  assign first      = first_p1;
  assign last_x     = last_x_p1;
  assign last_y     = last_y_p1;
  assign r          = r_p1;
  assign g          = g_p1;
  assign b          = b_p1;
  assign frame_done = vld_p1 && ready && last_y_p1;
endmodule

// File: tb/tb_pixel_reorder_stream.sv
// Directed bench for pixel_reorder_stream on a 4x2 frame with two engine channels,
// backed by a raster-order reference model checked on every cycle.
module tb_pixel_reorder_stream;
  localparam int NE = 2, PW = 4, IW = 6, SD = 4, HR = 4, VR = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] iterations_max = 6'd63;
  logic          colour_mode = 1'b0;
  logic [NE-1:0] eng_valid = '0;
  logic [NE-1:0] eng_ready;
  logic [NE*PW-1:0] eng_x = '0, eng_y = '0;
  logic [NE*IW-1:0] eng_iter = '0;
  logic          ready = 1'b1;
  logic [7:0]    r, g, b;
  logic          valid, first, last_x, last_y, frame_done, order_err;

  int checks = 0;
  int errors = 0;
  int tab [HR*VR];
  int mx = 0, my = 0, m_imax = 63;
  bit m_mode = 1'b0;

  pixel_reorder_stream #(.NUM_ENGINES(NE), .PIXEL_W(PW), .ITER_W(IW), .SLOT_DEPTH(SD),
                         .H_RES(HR), .V_RES(VR)) dut (
    .clk(clk), .reset(reset), .iterations_max(iterations_max), .colour_mode(colour_mode),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_x(eng_x), .eng_y(eng_y),
    .eng_iter(eng_iter), .ready(ready), .r(r), .g(g), .b(b), .valid(valid), .first(first),
    .last_x(last_x), .last_y(last_y), .frame_done(frame_done), .order_err(order_err));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int it, input int imax, input bit mode);
    int s;
    if (it == imax) return 24'h0;
    s = (it * (1 << (8 - IW))) % 256;
    if (!mode) return {8'(s), 8'(s), 8'(s)};
    return {8'(s), 8'(255 - s), 8'h80};
  endfunction

  // Reference: pixels leave in raster order, colour from the frame's captured settings
  always @(negedge clk) begin
    if (reset) begin
      mx = 0;
      my = 0;
    end else begin
      check("frame_done", frame_done, valid && ready && mx == HR-1 && my == VR-1);
      if (valid) begin
        logic [23:0] e;
        bit org;
        org = (mx == 0 && my == 0);
        e = org ? model_rgb(tab[my*HR+mx], int'(iterations_max), colour_mode)
                : model_rgb(tab[my*HR+mx], m_imax, m_mode);
        check("model_rgb", {r, g, b}, e);
        check("model_first", first, org);
        check("model_last_x", last_x, mx == HR-1);
        check("model_last_y", last_y, mx == HR-1 && my == VR-1);
        if (ready) begin
          if (org) begin
            m_imax = int'(iterations_max);
            m_mode = colour_mode;
          end
          mx = mx + 1;
          if (mx == HR) begin
            mx = 0;
            my = (my == VR-1) ? 0 : my + 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input int x, input int y, input int it);
    eng_valid[ch] = 1'b1;
    eng_x[ch*PW +: PW] = PW'(x);
    eng_y[ch*PW +: PW] = PW'(y);
    eng_iter[ch*IW +: IW] = IW'(it);
    if (x < HR && y < VR) tab[y*HR+x] = it;
  endtask

  task automatic push1(input int ch, input int x, input int y, input int it);
    load(ch, x, y, it);
    tick();
    eng_valid = '0;
  endtask

  task automatic push2(input int x0, input int y0, input int i0,
                       input int x1, input int y1, input int i1);
    load(0, x0, y0, i0);
    load(1, x1, y1, i1);
    tick();
    eng_valid = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    eng_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n = 0;
    @(negedge clk);
    while (!valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL %s: valid never rose within %0d cycles", name, bound);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    for (int i = 0; i < HR*VR; i++) tab[i] = 0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_first", first, 0);
    check("rst_rgb", {r, g, b}, 0);
    check("rst_order_err", order_err, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_eng_ready", eng_ready, 2'b11);

    // Out-of-order arrival across channels
    push1(1, 1, 0, 5);
    push1(0, 0, 0, 2);
    wait_valid("t1_first_wait", 10);
    check("t1_first", first, 1);
    check("t1_rgb0", {r, g, b}, 24'h080808);
    @(negedge clk);
    check("t1_second_valid", valid, 1);
    check("t1_second_first", first, 0);
    check("t1_rgb1", {r, g, b}, 24'h141414);
    @(negedge clk);
    check("t1_idle", valid, 0);

    // Backpressure, full FIFO and full-frame flags
    do_reset();
    ready = 1'b0;
    push1(0, 1, 0, 1);
    push1(0, 2, 0, 2);
    push1(0, 3, 0, 3);
    push1(0, 0, 1, 4);
    @(negedge clk);
    check("t2_ready_full", eng_ready, 2'b10);
    push1(1, 0, 0, 10);
    wait_valid("t2_wait", 10);
    check("t2_first", first, 1);
    check("t2_rgb", {r, g, b}, 24'h282828);
    tick(); tick(); tick();
    @(negedge clk);
    check("t2_hold_valid", valid, 1);
    check("t2_hold_rgb", {r, g, b}, 24'h282828);
    ready = 1'b1;
    push1(1, 1, 1, 5);
    push1(1, 2, 1, 6);
    push1(1, 3, 1, 7);
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("t2_frame_done", frame_done, 1);
    check("t2_last_x", last_x, 1);
    check("t2_last_y", last_y, 1);
    check("t2_last_rgb", {r, g, b}, 24'h1C1C1C);
    push1(0, 0, 0, 9);
    wait_valid("t2_next_wait", 10);
    check("t2_next_first", first, 1);
    check("t2_next_last_x", last_x, 0);

    // Colour modes and per-frame shadowing of settings
    do_reset();
    iterations_max = 6'd63;
    colour_mode = 1'b1;
    push1(0, 0, 0, 63);
    wait_valid("t3_wait0", 10);
    check("t3_inset_rgb", {r, g, b}, 24'h000000);
    tick();
    iterations_max = 6'd1;
    colour_mode = 1'b0;
    push1(0, 1, 0, 1);
    wait_valid("t3_wait1", 10);
    check("t3_twotone_rgb", {r, g, b}, 24'h04FB80);

    // Deadlock detection
    do_reset();
    iterations_max = 6'd63;
    push2(1, 1, 1, 2, 0, 1);
    push2(2, 1, 1, 3, 0, 1);
    push2(3, 1, 1, 0, 1, 1);
    push2(1, 0, 1, 1, 1, 1);
    @(negedge clk);
    check("t4_ready_none", eng_ready, 2'b00);
    check("t4_err_early", order_err, 0);
    tick(); tick();
    @(negedge clk);
    check("t4_err_set", order_err, 1);
    check("t4_no_out", valid, 0);
    repeat (5) tick();
    @(negedge clk);
    check("t4_err_sticky", order_err, 1);
    do_reset();
    @(negedge clk);
    check("t4_err_cleared", order_err, 0);
    check("t4_ready_all", eng_ready, 2'b11);

    // Out-of-range head is dropped and flagged without blocking the stream
    push1(0, 5, 0, 3);
    tick();
    @(negedge clk);
    check("t5_err_oob", order_err, 1);
    check("t5_no_out", valid, 0);
    push1(1, 0, 0, 8);
    wait_valid("t5_wait", 10);
    check("t5_first", first, 1);
    check("t5_rgb", {r, g, b}, 24'h202020);

    // Mid-frame reset discards buffered pixels
    do_reset();
    push1(0, 1, 0, 1);
    push1(0, 2, 0, 2);
    push1(1, 3, 0, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t6_valid", valid, 0);
    check("t6_ready_all", eng_ready, 2'b11);
    push1(0, 0, 0, 11);
    push1(1, 1, 0, 12);
    wait_valid("t6_wait", 10);
    check("t6_first", first, 1);
    check("t6_rgb0", {r, g, b}, 24'h2C2C2C);
    @(negedge clk);
    check("t6_rgb1", {r, g, b}, 24'h303030);
    @(negedge clk);
    check("t6_discarded", valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
